// File: rtl/ask_pkg.sv
// ---------------------------------------------------------------------------
// ask_pkg
//  Shared ASK definitions, used by both the transmit and receive paths.
//  AD_W     ADC sample width
//  WIN_LEN  default samples per decision window (one carrier period)
//  THRESH   default peak-to-peak slice level; pp >= THRESH decodes as 0
//  DEGL_N   default number of agreeing windows before the deglitched output moves
//  WIN_W    window counter width
// ---------------------------------------------------------------------------
package ask_pkg;

    localparam int AD_W    = 8;
    localparam int WIN_LEN = 100;
    localparam int THRESH  = 192;
    localparam int DEGL_N  = 2;
    localparam int WIN_W   = $clog2(WIN_LEN);

    typedef logic [AD_W-1:0] sample_t;

    // Full swing decodes as 0, reduced swing as 1. A tie counts as full swing.
    function automatic logic slice_bit(input sample_t pp, input sample_t thresh);
        return (pp < thresh);
    endfunction

endpackage

// File: rtl/ask_demodulator_if.sv
// ---------------------------------------------------------------------------
// ask_demodulator_if
//  ADC-side and decision-side signals of the ASK receiver.
//  ad_data     ADC sample (into the demodulator)
//  ad_clk      ADC sample clock (out of the demodulator)
//  data_out    recovered bit
//  data_valid  one-cycle strobe per window decision
//  data_edge   one-cycle strobe when data_out changed at that decision
//  pp_level    last window's peak-to-peak amplitude
//  modport slave  : the demodulator
//  modport master : ADC source / downstream consumer
// ---------------------------------------------------------------------------
interface ask_demodulator_if;
    import ask_pkg::*;

    sample_t ad_data;
    logic    ad_clk;
    logic    data_out;
    logic    data_valid;
    logic    data_edge;
    sample_t pp_level;

    modport slave (
        input  ad_data,
        output ad_clk,
        output data_out,
        output data_valid,
        output data_edge,
        output pp_level
    );

    modport master (
        output ad_data,
        input  ad_clk,
        input  data_out,
        input  data_valid,
        input  data_edge,
        input  pp_level
    );

endinterface

// File: rtl/ask_pp_detect.sv
// ---------------------------------------------------------------------------
// ask_pp_detect
//  Peak-to-peak amplitude detector over fixed windows of WIN_LEN samples.
//  Stages: S0 sample register, S1 window counter + max/min tracking + hold
//  registers, S2 pp = max - min.
//  clk_100m    in   system clock
//  rst         in   async active-low reset
//  i_ad_data   in   ADC sample
//  o_pp        out  peak-to-peak of the last completed window (held)
//  o_pp_valid  out  one-cycle strobe when o_pp takes a new value
// ---------------------------------------------------------------------------
module ask_pp_detect
    import ask_pkg::*;
#(
    parameter int WIN_LEN = ask_pkg::WIN_LEN
) (
    input  logic    clk_100m,
    input  logic    rst,
    input  sample_t i_ad_data,
    output sample_t o_pp,
    output logic    o_pp_valid
);

    localparam int               CNT_W = $clog2(WIN_LEN);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIN_LEN - 1);

    sample_t          r_ad_q;
    logic             r_q_vld;      // r_ad_q holds a real sample (not the reset value)
    logic [CNT_W-1:0] r_win_cnt;
    sample_t          r_max;
    sample_t          r_min;
    sample_t          r_max_h;
    sample_t          r_min_h;
    logic [1:0]       r_vld_pipe;   // [0]: hold regs fresh, [1]: pp fresh
    sample_t          r_pp;

    sample_t          w_max_n;
    sample_t          w_min_n;

    // The first sample of a window reloads the trackers, so nothing carries
    // over from the previous window.
    always_comb begin
        w_max_n = r_max;
        w_min_n = r_min;
        if (r_win_cnt == '0) begin
            w_max_n = r_ad_q;
            w_min_n = r_ad_q;
        end else begin
            if (r_ad_q > r_max) w_max_n = r_ad_q;
            if (r_ad_q < r_min) w_min_n = r_ad_q;
        end
    end

    always_ff @(posedge clk_100m or negedge rst) begin
        if (!rst) begin
            r_ad_q     <= '0;
            r_q_vld    <= 1'b0;
            r_win_cnt  <= '0;
            r_max      <= '0;
            r_min      <= '0;
            r_max_h    <= '0;
            r_min_h    <= '0;
            r_vld_pipe <= '0;
            r_pp       <= '0;
        end else begin
            r_ad_q        <= i_ad_data;
            r_q_vld       <= 1'b1;
            r_vld_pipe[0] <= 1'b0;
            if (r_q_vld) begin
                r_max <= w_max_n;
                r_min <= w_min_n;
                // Hold latch uses the next-state values so the window's
                // last sample is included; wrap happens on the same edge.
                if (r_win_cnt == LAST) begin
                    r_win_cnt     <= '0;
                    r_max_h       <= w_max_n;
                    r_min_h       <= w_min_n;
                    r_vld_pipe[0] <= 1'b1;
                end else begin
                    r_win_cnt <= r_win_cnt + CNT_W'(1);
                end
            end
            r_vld_pipe[1] <= r_vld_pipe[0];
            if (r_vld_pipe[0]) r_pp <= r_max_h - r_min_h;
        end
    end

    assign o_pp       = r_pp;
    assign o_pp_valid = r_vld_pipe[1];

endmodule

// File: rtl/ask_demodulator.sv
// ---------------------------------------------------------------------------
// ask_demodulator
//  ASK receiver: measures peak-to-peak amplitude of the ADC stream over
//  windows of WIN_LEN samples and slices it against THRESH.
//  Full swing -> 0, reduced swing -> 1.
//  clk_100m   in   100 MHz system clock
//  rst        in   async active-low reset
//  bus        ask_demodulator_if.slave (ad_data in; ad_clk, data_out,
//             data_valid, data_edge, pp_level out)
//  Build option ASK_DEMOD_DEGLITCH_EN: data_out only moves after DEGL_N
//  consecutive windows slice to the new value.
// ---------------------------------------------------------------------------
module ask_demodulator
    import ask_pkg::*;
#(
    parameter int WIN_LEN = ask_pkg::WIN_LEN,
    parameter int THRESH  = ask_pkg::THRESH
`ifdef ASK_DEMOD_DEGLITCH_EN
    ,
    parameter int DEGL_N  = ask_pkg::DEGL_N
`endif
) (
    input  logic clk_100m,
    input  logic rst,
    ask_demodulator_if.slave bus
);

    sample_t w_pp;
    logic    w_pp_vld;
    logic    w_slice;

    logic    r_data_out;
    logic    r_data_valid;
    logic    r_data_edge;

    ask_pp_detect #(
        .WIN_LEN (WIN_LEN)
    ) u_pp_detect (
        .clk_100m   (clk_100m),
        .rst        (rst),
        .i_ad_data  (bus.ad_data),
        .o_pp       (w_pp),
        .o_pp_valid (w_pp_vld)
    );

    assign w_slice = slice_bit(w_pp, sample_t'(THRESH));

`ifdef ASK_DEMOD_DEGLITCH_EN
    localparam int DG_W = $clog2(DEGL_N + 1);

    // Counts consecutive windows that disagree with data_out.
    logic [DG_W-1:0] r_agree_cnt;

    always_ff @(posedge clk_100m or negedge rst) begin
        if (!rst) begin
            r_data_out   <= 1'b0;
            r_data_valid <= 1'b0;
            r_data_edge  <= 1'b0;
            r_agree_cnt  <= '0;
        end else begin
            r_data_valid <= w_pp_vld;
            r_data_edge  <= 1'b0;
            if (w_pp_vld) begin
                if (w_slice == r_data_out) begin
                    r_agree_cnt <= '0;
                end else if (r_agree_cnt == DG_W'(DEGL_N - 1)) begin
                    r_data_out  <= w_slice;
                    r_data_edge <= 1'b1;
                    r_agree_cnt <= '0;
                end else begin
                    r_agree_cnt <= r_agree_cnt + DG_W'(1);
                end
            end
        end
    end
`else
    always_ff @(posedge clk_100m or negedge rst) begin
        if (!rst) begin
            r_data_out   <= 1'b0;
            r_data_valid <= 1'b0;
            r_data_edge  <= 1'b0;
        end else begin
            r_data_valid <= w_pp_vld;
            r_data_edge  <= 1'b0;
            if (w_pp_vld) begin
                r_data_edge <= (w_slice != r_data_out);
                r_data_out  <= w_slice;
            end
        end
    end
`endif

    // ADC samples on the falling edge of clk_100m, so its data is settled
    // for our rising edge.
    assign bus.ad_clk     = ~clk_100m;
    assign bus.data_out   = r_data_out;
    assign bus.data_valid = r_data_valid;
    assign bus.data_edge  = r_data_edge;
    assign bus.pp_level   = w_pp;

endmodule

// File: tb/tb_ask_demodulator.sv
// ---------------------------------------------------------------------------
// tb_ask_demodulator
//  Directed stimulus (sines, squares, bit pattern, constant, resets) with a
//  window-level amplitude model checked every cycle, plus literal
//  expectations on logged decisions. Honors ASK_DEMOD_DEGLITCH_EN.
// ---------------------------------------------------------------------------
module tb_ask_demodulator;
    import ask_pkg::*;

    logic clk_100m = 1'b0;
    logic rst      = 1'b0;

    ask_demodulator_if u_if ();

    ask_demodulator u_dut (
        .clk_100m (clk_100m),
        .rst      (rst),
        .bus      (u_if)
    );

    always #5 clk_100m = ~clk_100m;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Stimulus: 0 full sine, 1 half sine, 2 square 32/224, 3 square 32/223, 4 constant
    function automatic sample_t gen(input int kind, input int ph);
        real s;
        int  v;
        s = $sin(6.283185307179586 * real'(ph) / 100.0);
        v = $rtoi(127.5 + 127.5 * s + 0.5);
        if (v > 255) v = 255;
        if (v < 0)   v = 0;
        case (kind)
            0:       return sample_t'(v);
            1:       return sample_t'(v >> 1);
            2:       return (ph < 50) ? 8'd32 : 8'd224;
            3:       return (ph < 50) ? 8'd32 : 8'd223;
            4:       return 8'h80;
            default: return 8'h00;
        endcase
    endfunction

    int sc = 0;

    // Called at a falling edge; returns at a falling edge.
    task automatic drive_n(input int kind, input int nsamp);
        for (int i = 0; i < nsamp; i++) begin
            u_if.ad_data = gen(kind, sc % 100);
            sc++;
            @(negedge clk_100m);
        end
    endtask

    task automatic drive(input int kind, input int nwin);
        drive_n(kind, nwin * WIN_LEN);
    endtask

    // ---------------- model ----------------
    typedef struct {
        int e;
        int pp;
    } ev_t;

    int      n;
    sample_t win_q[$];
    ev_t     evq[$];
    int      m_out, m_pp, m_run, m_last;

    // DUT decision log, indexed by window number since the last reset
    int win_pp   [0:63];
    int win_out  [0:63];
    int win_edge [0:63];
    int widx;
    int first_vld;

    always @(posedge clk_100m) begin
        int  mx, mn, b, nb, exp_v, exp_e;
        ev_t ev;
        if (!rst) begin
            n = 0;
            win_q.delete();
            evq.delete();
            m_out = 0; m_pp = 0; m_run = 0; m_last = 0;
            widx = 0;
            first_vld = -1;
        end else begin
            n++;
            win_q.push_back(u_if.ad_data);
            if (win_q.size() == WIN_LEN) begin
                mx = 0; mn = 255;
                foreach (win_q[k]) begin
                    if (int'(win_q[k]) > mx) mx = int'(win_q[k]);
                    if (int'(win_q[k]) < mn) mn = int'(win_q[k]);
                end
                // Decision visible 3 edges after the edge capturing the last sample
                evq.push_back('{e: n + 3, pp: mx - mn});
                win_q.delete();
            end
        end
        #1;
        exp_v = 0;
        exp_e = 0;
        if (rst && evq.size() > 0) begin
            if (evq[0].e == n + 1) m_pp = evq[0].pp;
            if (evq[0].e == n) begin
                ev    = evq.pop_front();
                exp_v = 1;
                b     = (ev.pp < THRESH) ? 1 : 0;
`ifdef ASK_DEMOD_DEGLITCH_EN
                m_run  = (m_run > 0 && b == m_last) ? m_run + 1 : 1;
                m_last = b;
                nb     = (b != m_out && m_run >= DEGL_N) ? b : m_out;
`else
                nb = b;
`endif
                exp_e = (nb != m_out) ? 1 : 0;
                m_out = nb;
            end
        end
        if (rst && u_if.data_valid) begin
            if (first_vld < 0) first_vld = n;
            if (widx < 64) begin
                win_pp[widx]   = int'(u_if.pp_level);
                win_out[widx]  = int'(u_if.data_out);
                win_edge[widx] = int'(u_if.data_edge);
            end
            widx++;
        end
        chk("data_valid", int'(u_if.data_valid), exp_v);
        chk("data_edge",  int'(u_if.data_edge),  exp_e);
        chk("data_out",   int'(u_if.data_out),   m_out);
        chk("pp_level",   int'(u_if.pp_level),   m_pp);
        chk("ad_clk",     int'(u_if.ad_clk),     0);
    end

    // ---------------- stimulus ----------------
    int pat [5] = '{1, 0, 1, 1, 0};
    int esum;

    initial begin
        u_if.ad_data = 8'h00;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_100m);
            u_if.ad_data = (i % 2 == 1) ? 8'hFF : 8'h00;
        end
        @(negedge clk_100m);
        rst = 1'b1;
        sc  = 0;

        drive(0, 3);                                  // W0-2
        drive(1, 3);                                  // W3-5
        drive(2, 2);                                  // W6-7
        drive(3, 2);                                  // W8-9
        foreach (pat[i]) drive(pat[i] == 1 ? 1 : 0, 4); // W10-29
        drive(0, 3);                                  // W30-32
        drive(1, 1);                                  // W33
        drive(0, 3);                                  // W34-36
        drive(4, 2);                                  // W37-38
        drive_n(4, 10);

        chk("first_valid_edge", first_vld, WIN_LEN + 3);
        chk("window_count", widx, 39);
        chk("w1_pp_full", win_pp[1], 255);
        chk("w2_out_full", win_out[2], 0);
        chk("w4_pp_half", win_pp[4], 127);
        chk("w5_out_half", win_out[5], 1);
`ifdef ASK_DEMOD_DEGLITCH_EN
        chk("w4_edge_full_to_half", win_edge[4], 1);
        chk("w33_out_glitch", win_out[33], 0);
`else
        chk("w3_edge_full_to_half", win_edge[3], 1);
        chk("w33_out_glitch", win_out[33], 1);
`endif
        chk("w6_pp_sq224", win_pp[6], 192);
        chk("w7_out_sq224", win_out[7], 0);
        chk("w8_pp_sq223", win_pp[8], 191);
        chk("w9_out_sq223", win_out[9], 1);
        chk("w13_out_pat", win_out[13], 1);
        chk("w17_out_pat", win_out[17], 0);
        chk("w25_out_pat", win_out[25], 1);
        chk("w29_out_pat", win_out[29], 0);
        esum = 0;
        for (int i = 30; i <= 36; i++) esum += win_edge[i];
`ifdef ASK_DEMOD_DEGLITCH_EN
        chk("glitch_edges", esum, 0);
`else
        chk("glitch_edges", esum, 2);
`endif
        chk("w37_pp_const", win_pp[37], 0);
        chk("w38_out_const", win_out[38], 1);

        // Reset in the middle of a window
        drive_n(0, 40);
        rst = 1'b0;
        drive_n(0, 3);
        rst = 1'b1;
        drive(0, 1);
        drive_n(0, 10);
        chk("first_valid_after_midreset", first_vld, WIN_LEN + 3);
        chk("windows_after_midreset", widx, 1);
        chk("w0_pp_after_midreset", win_pp[0], 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
